// File: rtl/mux2_rr_sel_ctrl_if.sv
// Source/consumer bundle for the 2:1 round-robin select controller.
// The master side is the controller; the slave side is its environment.
interface mux2_rr_sel_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             ack_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             ack_b;
    logic             S;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        input  req_a, data_a, req_b, data_b, out_ready,
        output ack_a, ack_b, S, out_valid, out_data
    );

    modport slave (
        output req_a, data_a, req_b, data_b, out_ready,
        input  ack_a, ack_b, S, out_valid, out_data
    );
endinterface

// File: rtl/mux2_rr_sel_ctrl.sv
// Round-robin arbiter for sources A/B feeding a one-entry output buffer with select line S.
// Define MUX2_FIXED_PRIO_EN to make A win every contention (no round-robin history).
module mux2_rr_sel_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux2_rr_sel_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL_A = 2'd1,
        FULL_B = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_s;

    logic w_allow;
    logic w_grant_a;
    logic w_grant_b;

    // A buffered word is displaced either into an empty slot or in the same cycle it is popped.
    assign w_allow = !rst && ((r_state == EMPTY) || bus.out_ready);

`ifdef MUX2_FIXED_PRIO_EN
    assign w_grant_a = w_allow && bus.req_a;
    assign w_grant_b = w_allow && bus.req_b && !bus.req_a;
`else
    // r_last = 1 means B was granted most recently, so A wins the next tie.
    logic r_last;

    assign w_grant_a = w_allow && bus.req_a && (!bus.req_b || r_last);
    assign w_grant_b = w_allow && bus.req_b && (!bus.req_a || !r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant_a) begin
            r_last <= 1'b0;
        end else if (w_grant_b) begin
            r_last <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_s         <= 1'b0;
        end else if (w_grant_a) begin
            r_state     <= FULL_A;
            r_out_valid <= 1'b1;
            r_out_data  <= bus.data_a;
            r_s         <= 1'b0;
        end else if (w_grant_b) begin
            r_state     <= FULL_B;
            r_out_valid <= 1'b1;
            r_out_data  <= bus.data_b;
            r_s         <= 1'b1;
        end else if (w_allow) begin
            // Popped with nothing to replace it; S keeps pointing at the last source.
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
        end
    end

    assign bus.ack_a     = w_grant_a;
    assign bus.ack_b     = w_grant_b;
    assign bus.S         = r_s;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_mux2_rr_sel_ctrl.sv
// Bench for mux2_rr_sel_ctrl: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a buffer/priority model kept here.
module tb_mux2_rr_sel_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux2_rr_sel_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mux2_rr_sel_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: buffer contents plus who should win the next tie.
    bit         m_valid;
    logic [7:0] m_data;
    bit         m_s;
    bit         m_b_next;
    bit         e_ack_a;
    bit         e_ack_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // Apply inputs, let combinational acks settle, compare everything with the model.
    task automatic drive(input bit r, input bit ra, input logic [7:0] da,
                         input bit rb, input logic [7:0] db, input bit rdy);
        bit take;
        rst           = r;
        bus.req_a     = ra;
        bus.data_a    = da;
        bus.req_b     = rb;
        bus.data_b    = db;
        bus.out_ready = rdy;
        #1;
        take    = !r && (!m_valid || rdy);
        e_ack_a = take && ra && (!rb || !m_b_next);
        e_ack_b = take && rb && !e_ack_a;
        chk("ack_a", bus.ack_a, e_ack_a);
        chk("ack_b", bus.ack_b, e_ack_b);
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_data", bus.out_data, m_data);
        chk("S", bus.S, m_s);
    endtask

    task automatic tick();
        if (rst) begin
            m_valid = 0; m_data = 8'h00; m_s = 0; m_b_next = 0;
        end else if (e_ack_a) begin
            m_valid = 1; m_data = bus.data_a; m_s = 0; m_b_next = 1;
            $display("cycle %0d: grant A data=%02h", cyc, bus.data_a);
        end else if (e_ack_b) begin
            m_valid = 1; m_data = bus.data_b; m_s = 1; m_b_next = 0;
            $display("cycle %0d: grant B data=%02h", cyc, bus.data_b);
        end else if (!m_valid || bus.out_ready) begin
            m_valid = 0;
        end
`ifdef MUX2_FIXED_PRIO_EN
        m_b_next = 0;
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bit         ra, rb, r, rdy;
        logic [7:0] da, db;

        // Bring the design to a known state before any comparison.
        rst = 1'b1;
        bus.req_a = 0; bus.req_b = 0; bus.data_a = 0; bus.data_b = 0; bus.out_ready = 0;
        @(posedge clk); #1;
        m_valid = 0; m_data = 0; m_s = 0; m_b_next = 0;

        // Reset held two cycles with both sources requesting.
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 8'hAA, 1, 8'h55, 1);
            chk("rst_ack_a", bus.ack_a, 0);
            chk("rst_ack_b", bus.ack_b, 0);
            tick();
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_data", bus.out_data, 8'h00);
            chk("rst_S", bus.S, 0);
        end

        // Contention: A first after reset, then alternating (A only when fixed priority).
        for (int k = 0; k < 4; k++) begin
            bit pick_b;
`ifdef MUX2_FIXED_PRIO_EN
            pick_b = 0;
`else
            pick_b = (k % 2) == 1;
`endif
            drive(0, 1, 8'hAA, 1, 8'h55, 1);
            chk("cont_ack_a", bus.ack_a, !pick_b);
            chk("cont_ack_b", bus.ack_b, pick_b);
            tick();
            chk("cont_data", bus.out_data, pick_b ? 8'h55 : 8'hAA);
            chk("cont_S", bus.S, pick_b);
            chk("cont_valid", bus.out_valid, 1);
        end

        // Single source A.
        drive(0, 1, 8'h3C, 0, 8'h00, 1);
        chk("single_ack_a", bus.ack_a, 1);
        tick();
        chk("single_valid", bus.out_valid, 1);
        chk("single_data", bus.out_data, 8'h3C);
        chk("single_S", bus.S, 0);

        // Drain to empty from FULL_A.
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        tick();
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_S", bus.S, 0);

        // Load B word 11, then backpressure with A waiting.
        drive(0, 0, 8'h00, 1, 8'h11, 1);
        chk("loadb_ack_b", bus.ack_b, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 8'h77, 0, 8'h00, 0);
            chk("bp_ack_a", bus.ack_a, 0);
            tick();
            chk("bp_data", bus.out_data, 8'h11);
            chk("bp_S", bus.S, 1);
        end
        drive(0, 1, 8'h77, 0, 8'h00, 1);
        chk("bp_release_ack_a", bus.ack_a, 1);
        tick();
        chk("bp_release_data", bus.out_data, 8'h77);
        chk("bp_release_S", bus.S, 0);

        // Reset while FULL_B and stalled, then A wins the next contention.
        drive(0, 0, 8'h00, 1, 8'h22, 1);
        tick();
        drive(1, 1, 8'hAA, 1, 8'h55, 0);
        chk("midrst_ack_a", bus.ack_a, 0);
        chk("midrst_ack_b", bus.ack_b, 0);
        tick();
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_data", bus.out_data, 8'h00);
        chk("midrst_S", bus.S, 0);
        drive(0, 1, 8'hAA, 1, 8'h55, 1);
        chk("midrst_first_ack_a", bus.ack_a, 1);
        tick();
        chk("midrst_first_data", bus.out_data, 8'hAA);

        // Random traffic; a pending request usually holds its word until acked.
        ra = 0; rb = 0; da = 0; db = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ra || $urandom_range(0, 7) == 0) begin
                ra = $urandom_range(0, 1) == 1;
                da = 8'($urandom);
            end
            if (!rb || $urandom_range(0, 7) == 0) begin
                rb = $urandom_range(0, 1) == 1;
                db = 8'($urandom);
            end
            r   = $urandom_range(0, 49) == 0;
            rdy = $urandom_range(0, 3) != 0;
            drive(r, ra, da, rb, db, rdy);
            chk("one_hot_ack", bus.ack_a & bus.ack_b, 0);
            tick();
            if (e_ack_a) ra = 0;
            if (e_ack_b) rb = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
